// File: rtl/rect_plotter_if.sv
// rect_plotter_if: rectangle-fill command channel between the game-control
// FSM (master) and the rect_plotter draw engine (slave).
//   cmd_valid   master -> slave  command present
//   cmd_ready   slave  -> master command can be accepted this cycle
//   cmd_x/y     master -> slave  rectangle origin (left, top)
//   cmd_w/h     master -> slave  width/height in pixels, 0 = empty
//   cmd_colour  master -> slave  fill colour
interface rect_plotter_if #(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic [COORD_W-1:0]  cmd_w;
  logic [COORD_W-1:0]  cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready
  );
endinterface

// File: rtl/rect_plotter.sv
// rect_plotter: turns rectangle-fill commands into a stream of framebuffer
// writes, one pixel per clock, row-major from the top-left, clipped to the
// X_MAX x Y_MAX screen. Holds one active command and one pending command so
// back-to-back commands draw without bubbles.
// Ports:
//   clk      system clock (shared with the VGA adapter)
//   rst      synchronous active-low reset
//   cmd      command channel (slave side of rect_plotter_if)
//   x/y      pixel coordinate to the adapter (registered)
//   colour   pixel colour to the adapter (registered)
//   plot     write strobe, x/y/colour valid when high (registered)
//   busy     drawing, finishing an empty command, or a command pending
//   done     one-cycle pulse when an accepted command completes (registered)
module rect_plotter #(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120
) (
  input  logic                clk,
  input  logic                rst,
  rect_plotter_if.slave       cmd,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [COORD_W:0]   X_LIM = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]   Y_LIM = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W-1:0] ONE   = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] ZERO  = {COORD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_EMPTY = 2'd2
  } state_e;

  // Visible length of one axis: nothing if the origin is off-screen,
  // otherwise the requested length trimmed at the screen edge.
  function automatic logic [COORD_W-1:0] clip_len(
    input logic [COORD_W-1:0] org,
    input logic [COORD_W-1:0] len,
    input logic [COORD_W:0]   lim
  );
    logic [COORD_W:0]   room;
    logic [COORD_W-1:0] res;
    room = lim - {1'b0, org};
    if ({1'b0, org} >= lim) begin
      res = ZERO;
    end else if ({1'b0, len} < room) begin
      res = len;
    end else begin
      res = room[COORD_W-1:0];
    end
    return res;
  endfunction

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [COORD_W-1:0]   ew_q, ew_d, eh_q, eh_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [COLOUR_W-1:0]  acol_q, acol_d;
  logic                 pend_full_q, pend_full_d;
  logic [COORD_W-1:0]   px_q, px_d, py_q, py_d, pw_q, pw_d, ph_q, ph_d;
  logic [COLOUR_W-1:0]  pcol_q, pcol_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  logic                 plot_q, plot_d, done_q, done_d;

  logic                 accept_s, last_s, load_s, use_pend_s;
  logic [COORD_W-1:0]   src_x_s, src_y_s, src_w_s, src_h_s;
  logic [COLOUR_W-1:0]  src_col_s;
  logic [COORD_W-1:0]   clip_w_s, clip_h_s;

  // Next-state, pixel generation and command load/queue decisions.
  always_comb begin
    state_d     = state_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    ew_d        = ew_q;
    eh_d        = eh_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    acol_d      = acol_q;
    pend_full_d = pend_full_q;
    px_d        = px_q;
    py_d        = py_q;
    pw_d        = pw_q;
    ph_d        = ph_q;
    pcol_d      = pcol_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    done_d      = 1'b0;
    last_s      = 1'b0;
    load_s      = 1'b0;
    use_pend_s  = 1'b0;

    accept_s = cmd.cmd_valid && !pend_full_q;

    case (state_q)
      ST_IDLE: begin
        load_s = accept_s;
      end
      ST_DRAW: begin
        plot_d   = 1'b1;
        x_d      = ox_q + cx_q;
        y_d      = oy_q + cy_q;
        colour_d = acol_q;
        if ((cx_q == ew_q - ONE) && (cy_q == eh_q - ONE)) begin
          done_d = 1'b1;
          last_s = 1'b1;
        end else if (cx_q == ew_q - ONE) begin
          cx_d = ZERO;
          cy_d = cy_q + ONE;
        end else begin
          cx_d = cx_q + ONE;
        end
      end
      ST_EMPTY: begin
        done_d = 1'b1;
        last_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Finishing a command: the pending slot has priority; a same-cycle accept
    // can only happen when pending is empty because cmd_ready is low otherwise.
    if (last_s) begin
      if (pend_full_q) begin
        use_pend_s  = 1'b1;
        load_s      = 1'b1;
        pend_full_d = 1'b0;
      end else if (accept_s) begin
        load_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (accept_s && (state_q != ST_IDLE)) begin
      pend_full_d = 1'b1;
      px_d        = cmd.cmd_x;
      py_d        = cmd.cmd_y;
      pw_d        = cmd.cmd_w;
      ph_d        = cmd.cmd_h;
      pcol_d      = cmd.cmd_colour;
    end else begin
      pend_full_d = pend_full_q;
    end

    src_x_s   = use_pend_s ? px_q   : cmd.cmd_x;
    src_y_s   = use_pend_s ? py_q   : cmd.cmd_y;
    src_w_s   = use_pend_s ? pw_q   : cmd.cmd_w;
    src_h_s   = use_pend_s ? ph_q   : cmd.cmd_h;
    src_col_s = use_pend_s ? pcol_q : cmd.cmd_colour;
    clip_w_s  = clip_len(src_x_s, src_w_s, X_LIM);
    clip_h_s  = clip_len(src_y_s, src_h_s, Y_LIM);

    if (load_s) begin
      ox_d    = src_x_s;
      oy_d    = src_y_s;
      ew_d    = clip_w_s;
      eh_d    = clip_h_s;
      acol_d  = src_col_s;
      cx_d    = ZERO;
      cy_d    = ZERO;
      state_d = ((clip_w_s != ZERO) && (clip_h_s != ZERO)) ? ST_DRAW : ST_EMPTY;
    end else begin
      acol_d = acol_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ox_q        <= ZERO;
      oy_q        <= ZERO;
      ew_q        <= ZERO;
      eh_q        <= ZERO;
      cx_q        <= ZERO;
      cy_q        <= ZERO;
      acol_q      <= {COLOUR_W{1'b0}};
      pend_full_q <= 1'b0;
      px_q        <= ZERO;
      py_q        <= ZERO;
      pw_q        <= ZERO;
      ph_q        <= ZERO;
      pcol_q      <= {COLOUR_W{1'b0}};
      x_q         <= ZERO;
      y_q         <= ZERO;
      colour_q    <= {COLOUR_W{1'b0}};
      plot_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      ew_q        <= ew_d;
      eh_q        <= eh_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      acol_q      <= acol_d;
      pend_full_q <= pend_full_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pw_q        <= pw_d;
      ph_q        <= ph_d;
      pcol_q      <= pcol_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      done_q      <= done_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign colour        = colour_q;
  assign plot          = plot_q;
  assign done          = done_q;
  assign busy          = (state_q != ST_IDLE) || pend_full_q;
  assign cmd.cmd_ready = !pend_full_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Randomised and directed bench for rect_plotter. Expected pixel streams are
// built by enumerating every pixel of each accepted rectangle and keeping the
// on-screen ones, in raster order.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  rect_plotter_if #(.COORD_W(8), .COLOUR_W(3)) cmd_if ();

  rect_plotter #(.COORD_W(8), .COLOUR_W(3), .X_MAX(160), .Y_MAX(120)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd_if.slave),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    bit emp;
    int px;
    int py;
    int pc;
    bit last;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   plot_cnt = 0;
  int   run_len = 0;
  int   max_run = 0;
  int   hold_x = 0, hold_y = 0, hold_c = 0;
  logic rst_smp;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: every pixel of the rectangle, kept only if on screen.
  task automatic push_cmd(input int cx, input int cy, input int w, input int h, input int c);
    ev_t e;
    int  n = 0;
    for (int yy = cy; yy < cy + h; yy++) begin
      for (int xx = cx; xx < cx + w; xx++) begin
        if (xx < 160 && yy < 120) begin
          e.emp = 1'b0; e.px = xx; e.py = yy; e.pc = c; e.last = 1'b0;
          exp_q.push_back(e);
          n++;
        end
      end
    end
    if (n == 0) begin
      e.emp = 1'b1; e.px = 0; e.py = 0; e.pc = 0; e.last = 1'b1;
      exp_q.push_back(e);
    end else begin
      exp_q[exp_q.size()-1].last = 1'b1;
    end
  endtask

  always @(posedge clk) rst_smp <= rst;

  // Output monitor: every plot/done is matched against the reference queue.
  always @(negedge clk) begin
    if (rst_smp !== 1'b1) begin
      exp_q.delete();
      hold_x = 0; hold_y = 0; hold_c = 0;
      run_len = 0;
    end else begin
      if (plot === 1'b1) begin
        plot_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        check_eq("plot_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("pix_is_fill", mon_e.emp, 0);
          check_eq("pix_x", x, mon_e.px);
          check_eq("pix_y", y, mon_e.py);
          check_eq("pix_colour", colour, mon_e.pc);
          check_eq("pix_done", done, mon_e.last);
          hold_x = mon_e.px; hold_y = mon_e.py; hold_c = mon_e.pc;
        end
      end else begin
        run_len = 0;
        check_eq("hold_x", x, hold_x);
        check_eq("hold_y", y, hold_y);
        check_eq("hold_colour", colour, hold_c);
        if (done === 1'b1) begin
          check_eq("done_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("done_is_empty_cmd", mon_e.emp, 1);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic send(input int sx, input int sy, input int sw, input int sh, input int sc,
                      output int waits);
    bit r;
    bit ok;
    ok = 1'b0;
    waits = 0;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_x      = 8'(sx);
    cmd_if.cmd_y      = 8'(sy);
    cmd_if.cmd_w      = 8'(sw);
    cmd_if.cmd_h      = 8'(sh);
    cmd_if.cmd_colour = 3'(sc);
    for (int i = 0; i < 400 && !ok; i++) begin
      r = cmd_if.cmd_ready;
      @(posedge clk);
      if (r) begin
        push_cmd(sx, sy, sw, sh, sc);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        waits++;
      end
    end
    if (!ok) check_eq("accept_timeout", ok, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    idle();
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue", exp_q.size(), 0);
    check_eq("drain_busy", busy, 0);
    @(posedge clk);
  endtask

  int w0, w1, w2, pc0, dc0;

  initial begin
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x = 8'd0; cmd_if.cmd_y = 8'd0; cmd_if.cmd_w = 8'd0; cmd_if.cmd_h = 8'd0;
    cmd_if.cmd_colour = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_colour", colour, 0);
    check_eq("rst_plot", plot, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_if.cmd_ready, 1);
    rst = 1'b1;

    // 2x2 fill with latency check
    dc0 = done_cnt; pc0 = plot_cnt;
    send(10, 52, 2, 2, 7, w0);
    idle();
    check_eq("t1_lat_pre", plot, 0);
    @(negedge clk);
    check_eq("t1_first_plot", plot, 1);
    check_eq("t1_first_x", x, 10);
    check_eq("t1_first_y", y, 52);
    drain(50);
    check_eq("t1_plots", plot_cnt - pc0, 4);
    check_eq("t1_dones", done_cnt - dc0, 1);

    // empty command: done one cycle after accept, no plots
    dc0 = done_cnt; pc0 = plot_cnt;
    send(5, 5, 0, 5, 1, w0);
    idle();
    check_eq("t2_done_early", done, 0);
    check_eq("t2_ready_a", cmd_if.cmd_ready, 1);
    @(negedge clk);
    check_eq("t2_done", done, 1);
    check_eq("t2_ready_b", cmd_if.cmd_ready, 1);
    drain(20);
    check_eq("t2_plots", plot_cnt - pc0, 0);

    // clipped corner and fully off-screen
    pc0 = plot_cnt;
    send(158, 118, 4, 4, 4, w0);
    drain(50);
    check_eq("t3_corner_plots", plot_cnt - pc0, 4);
    dc0 = done_cnt; pc0 = plot_cnt;
    send(200, 10, 3, 3, 2, w0);
    drain(20);
    check_eq("t3_off_plots", plot_cnt - pc0, 0);
    check_eq("t3_off_dones", done_cnt - dc0, 1);

    // back-to-back with pending
    dc0 = done_cnt; pc0 = plot_cnt; max_run = 0;
    send(20, 30, 3, 1, 1, w0);
    send(40, 40, 1, 1, 2, w1);
    send(50, 50, 1, 1, 3, w2);
    drain(50);
    check_eq("t4_b_waits", w1, 0);
    check_eq("t4_c_waits", w2, 2);
    check_eq("t4_plots", plot_cnt - pc0, 5);
    check_eq("t4_run", max_run, 5);
    check_eq("t4_dones", done_cnt - dc0, 3);

    // full screen
    dc0 = done_cnt; pc0 = plot_cnt; max_run = 0;
    send(0, 0, 160, 120, 0, w0);
    drain(20000);
    check_eq("t5_plots", plot_cnt - pc0, 19200);
    check_eq("t5_run", max_run, 19200);
    check_eq("t5_dones", done_cnt - dc0, 1);

    // reset in the middle of a fill
    send(0, 0, 160, 120, 5, w0);
    idle();
    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_plot", plot, 0);
    check_eq("t6_ready", cmd_if.cmd_ready, 1);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    rst = 1'b1;
    pc0 = plot_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_no_stale", plot_cnt - pc0, 0);
    send(77, 88, 1, 1, 6, w0);
    drain(20);
    check_eq("t6_new_plots", plot_cnt - pc0, 1);

    // random commands, some back-to-back
    dc0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 200), $urandom_range(0, 140), $urandom_range(0, 12),
           $urandom_range(0, 12), $urandom_range(0, 7), w0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    drain(5000);
    check_eq("t7_dones", done_cnt - dc0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
- Draw engine between the game-control FSM and the VGA framebuffer adapter.
- Accepts rectangle-fill commands (origin, width, height, colour) over a valid/ready handshake.
- Emits one framebuffer write per clock (x, y, colour, plot) in raster order, clipped to the 160x120 screen.
- Lets the game FSM issue paddle, ball, centre-line and background draws as single commands instead of running its own pixel counters.

Parameters:
- COORD_W, 8, width of x/y coordinates and of width/height fields.
- COLOUR_W, 3, colour width (1 bit per channel).
- X_MAX, 160, screen width; pixels with x >= X_MAX are never emitted.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are never emitted.

Ports:
- clk  input  1  system clock (same clock as the VGA adapter).
- rst  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_x  input  COORD_W  rectangle origin x (left).
- cmd_y  input  COORD_W  rectangle origin y (top).
- cmd_w  input  COORD_W  width in pixels; 0 = empty.
- cmd_h  input  COORD_W  height in pixels; 0 = empty.
- cmd_colour  input  COLOUR_W  fill colour.
- x  output  COORD_W  pixel x to the adapter.
- y  output  COORD_W  pixel y to the adapter.
- colour  output  COLOUR_W  pixel colour to the adapter.
- plot  output  1  write strobe; x/y/colour valid when high.
- busy  output  1  engine drawing or a command pending.
- done  output  1  one-cycle pulse at completion of each accepted command.

Behaviour:
- Reset, sampled on posedge clk when rst==0: x=0, y=0, colour=0, plot=0, done=0, busy=0, cmd_ready=1. Active and pending commands are discarded. This also applies mid-draw: the next cycle has plot=0 and no further pixels of the aborted command are emitted.
- Storage: one active-command register set and one pending register.
  - cmd_ready = ~pending_full; combinational from state only, never from cmd_valid.
  - Handshake completes when cmd_valid && cmd_ready on a clock edge.
- Load on accept:
  - If the engine is IDLE, or is emitting its last pixel this cycle, the command goes straight to active.
  - Otherwise it goes to pending.
- Clip at load, using (COORD_W+1)-bit arithmetic:
  - eff_w = (cmd_x >= X_MAX) ? 0 : min(cmd_w, X_MAX - cmd_x).
  - eff_h = (cmd_y >= Y_MAX) ? 0 : min(cmd_h, Y_MAX - cmd_y).
- States:
  - IDLE: plot=0. On accept -> DRAW if eff_w and eff_h are both nonzero, else EMPTY.
  - DRAW: each cycle drives plot=1 with x=ox+cx, y=oy+cy, colour=active colour.
    - cx increments each cycle; at cx==eff_w-1, cx wraps to 0 and cy increments.
    - The last pixel is cx==eff_w-1 && cy==eff_h-1. On that cycle done=1 and the next command loads with no bubble: from pending if full, else from a same-cycle accept. Target state is DRAW or EMPTY by its clip result; IDLE if nothing is available.
  - EMPTY: one cycle, plot=0, done=1; then loads the next command as in DRAW, or goes to IDLE.
- Outputs x/y/colour/plot/done are registered.
  - Latency: accept at edge N -> first pixel (plot=1) visible after edge N+1.
  - Empty command accepted at edge N -> done visible after edge N+1.
- Rate: exactly eff_w*eff_h plot cycles per command, consecutive, row-major, top-left first.
- When plot=0, x/y/colour hold their last values.
- busy = (state != IDLE) || pending_full.
- Simultaneous events:
  - Accept during the last-pixel cycle with pending empty: the command becomes active directly and pending stays empty.
  - Pending full and last pixel: pending moves to active, and cmd_ready is 1 from the next cycle.
- Counters cx/cy are COORD_W bits. The clip guarantees ox+cx < X_MAX and oy+cy < Y_MAX, so there is no wrap past the screen edge.

Test Plan:
- Reset, then cmd (x=10,y=52,w=2,h=2,colour=7) -> plots (10,52),(11,52),(10,53),(11,53) on 4 consecutive cycles starting 1 cycle after accept; done with the 4th; busy low after.
- Cmd w=0,h=5 -> no plot; done=1 exactly 1 cycle after accept; cmd_ready stays 1.
- Cmd (x=158,y=118,w=4,h=4,colour=4) -> exactly 4 plots: (158,118),(159,118),(158,119),(159,119). Cmd x=200 -> zero plots, done pulse.
- Three back-to-back cmds A (w=3,h=1), B (w=1,h=1), C (w=1,h=1) with cmd_valid held:
  - A accepted, B goes to pending, cmd_ready=0 while C waits.
  - Plot stream is A0,A1,A2,B0,C0 with no gaps and 3 done pulses.
- Cmd (0,0,160,120,colour=0) -> 19200 consecutive plots ending at (159,119); done on the last; pixel count checked.
- Assert rst=0 for one cycle mid-way through a 160x120 fill -> plot=0 next cycle, cmd_ready=1, busy=0; no stale pixels afterwards; a new 1x1 cmd draws correctly.
